// File: rtl/alu_multicycle.sv
// Multi-cycle RV32 ALU with valid/ready handshakes, an iterative multiplier and an optional divider.
// Define ALU_DIV_EN to build the restoring divider; without it DIVU/REMU decode as undefined opcodes.
module alu_multicycle #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  localparam int SHAMT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult
);

  // state | meaning
  // IDLE  | waiting for an operation, in_ready=1
  // BUSY  | iterating MUL/DIVU/REMU, one step per cycle
  // DONE  | result presented, waiting for out_ready
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  localparam logic [OPCODE_LENGTH-1:0] OP_AND  = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR   = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL  = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL  = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ   = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_LUI  = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLTU = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] OP_MUL  = OPCODE_LENGTH'(4'b1100);
`ifdef ALU_DIV_EN
  localparam logic [OPCODE_LENGTH-1:0] OP_DIVU = OPCODE_LENGTH'(4'b1101);
  localparam logic [OPCODE_LENGTH-1:0] OP_REMU = OPCODE_LENGTH'(4'b1110);
`endif

  logic [1:0]               state;
  logic [CW-1:0]            count;
  logic [DATA_WIDTH-1:0]    opa;
  logic [DATA_WIDTH-1:0]    opb;
  logic [DATA_WIDTH-1:0]    acc;
  logic [OPCODE_LENGTH-1:0] iter_op;

  logic [DATA_WIDTH-1:0]    sc_res;
  logic                     is_iter;
  logic [DATA_WIDTH-1:0]    mul_acc_n;
  logic [DATA_WIDTH-1:0]    div_rem_n;
  logic [DATA_WIDTH-1:0]    div_quo_n;
  logic [DATA_WIDTH-1:0]    final_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    sc_res = '0;
    case (Operation)
      OP_AND:  sc_res = SrcA & SrcB;
      OP_OR:   sc_res = SrcA | SrcB;
      OP_ADD:  sc_res = SrcA + SrcB;
      OP_SUB:  sc_res = SrcA - SrcB;
      OP_XOR:  sc_res = SrcA ^ SrcB;
      OP_SLL:  sc_res = SrcA << SrcB[SHAMT_WIDTH-1:0];
      OP_SRL:  sc_res = SrcA >> SrcB[SHAMT_WIDTH-1:0];
      OP_EQ:   sc_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      OP_LUI:  sc_res = SrcB;
      OP_SLTU: sc_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
`ifdef ALU_DIV_EN
      // Only reached on a zero divisor; non-zero divisors take the iterative path.
      OP_DIVU: sc_res = '1;
      OP_REMU: sc_res = SrcA;
`endif
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    is_iter = (Operation == OP_MUL);
`ifdef ALU_DIV_EN
    if (((Operation == OP_DIVU) || (Operation == OP_REMU)) && (SrcB != '0))
      is_iter = 1'b1;
`endif
  end

  assign mul_acc_n = acc + (opb[0] ? opa : '0);

`ifdef ALU_DIV_EN
  // Restoring step: opa holds the divisor, opb shifts the dividend out and the quotient in.
  logic [DATA_WIDTH:0] trial;
  logic                div_ok;
  assign trial     = {acc, opb[DATA_WIDTH-1]} - {1'b0, opa};
  assign div_ok    = ~trial[DATA_WIDTH];
  assign div_rem_n = div_ok ? trial[DATA_WIDTH-1:0] : {acc[DATA_WIDTH-2:0], opb[DATA_WIDTH-1]};
  assign div_quo_n = {opb[DATA_WIDTH-2:0], div_ok};
`else
  assign div_rem_n = '0;
  assign div_quo_n = '0;
`endif

  always_comb begin
    final_res = mul_acc_n;
`ifdef ALU_DIV_EN
    if (iter_op == OP_DIVU)      final_res = div_quo_n;
    else if (iter_op == OP_REMU) final_res = div_rem_n;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      iter_op   <= '0;
      ALUResult <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_iter) begin
              iter_op <= Operation;
              acc     <= '0;
              count   <= CW'(DATA_WIDTH);
              state   <= BUSY;
              if (Operation == OP_MUL) begin
                opa <= SrcA;
                opb <= SrcB;
              end else begin
                opa <= SrcB;
                opb <= SrcA;
              end
            end else begin
              ALUResult <= sc_res;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          count <= count - CW'(1);
          if (iter_op == OP_MUL) begin
            acc <= mul_acc_n;
            opa <= opa << 1;
            opb <= opb >> 1;
          end else begin
            acc <= div_rem_n;
            opb <= div_quo_n;
          end
          if (count == CW'(1)) begin
            ALUResult <= final_res;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: vector table, random ops against a reference model,
// plus backpressure and mid-operation reset sequences. Expectations follow ALU_DIV_EN.
module tb_alu_multicycle;

`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  Operation;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;

  int checks = 0;
  int failures = 0;
  logic [31:0] sbq[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  alu_multicycle #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h3: return a - b;
      4'h4: return a ^ b;
      4'h6: return a << b[4:0];
      4'h7: return a >> b[4:0];
      4'h8: return (a == b) ? 32'd1 : 32'd0;
      4'h9: return b;
      4'hA: return (a < b) ? 32'd1 : 32'd0;
      4'hC: return a * b;
      4'hD: return !DIV_EN ? 32'd0 : (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'hE: return !DIV_EN ? 32'd0 : (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'hC) return 33;
    if (DIV_EN && (op == 4'hD || op == 4'hE) && b != 0) return 33;
    return 1;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    bit saw_ready;
    logic [31:0] e;
    wait_idle(name);
    SrcA = a; SrcB = b; Operation = op; in_valid = 1'b1;
    sbq.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    SrcA = $urandom; SrcB = $urandom; Operation = 4'($urandom_range(15));
    lat = 1;
    saw_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) saw_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_no_ready_busy"}, {31'd0, saw_ready}, 32'd0);
    e = sbq.pop_front();
    check({name, "_result"}, ALUResult, e);
    check({name, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check({name, "_released"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    SrcA = '0; SrcB = '0; Operation = '0;

    vecs.push_back('{4'h2, 32'd7,          32'd5,          32'd12,         1});
    vecs.push_back('{4'h1, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1});
    vecs.push_back('{4'h6, 32'd1,          32'd33,         32'd2,          1});
    vecs.push_back('{4'hC, 32'h0000_FFFF,  32'h0001_0001,  32'hFFFF_FFFF,  33});
    vecs.push_back('{4'hD, 32'd100,        32'd7,          DIV_EN ? 32'd14 : 32'd0, DIV_EN ? 33 : 1});
    vecs.push_back('{4'hE, 32'd100,        32'd7,          DIV_EN ? 32'd2 : 32'd0,  DIV_EN ? 33 : 1});
    vecs.push_back('{4'hD, 32'd5,          32'd0,          DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1});
    vecs.push_back('{4'hE, 32'd5,          32'd0,          DIV_EN ? 32'd5 : 32'd0,  1});
    vecs.push_back('{4'h3, 32'd3,          32'd5,          32'hFFFF_FFFE,  1});
    vecs.push_back('{4'h0, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1});
    vecs.push_back('{4'h4, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555,  1});
    vecs.push_back('{4'h7, 32'h8000_0000,  32'd31,         32'd1,          1});
    vecs.push_back('{4'h7, 32'h8000_0000,  32'd32,         32'h8000_0000,  1});
    vecs.push_back('{4'h8, 32'd5,          32'd5,          32'd1,          1});
    vecs.push_back('{4'h8, 32'd5,          32'd6,          32'd0,          1});
    vecs.push_back('{4'hA, 32'd1,          32'hFFFF_FFFF,  32'd1,          1});
    vecs.push_back('{4'hA, 32'hFFFF_FFFF,  32'd1,          32'd0,          1});
    vecs.push_back('{4'h9, 32'h1234_5678,  32'hABCD_E000,  32'hABCD_E000,  1});
    vecs.push_back('{4'h5, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1});
    vecs.push_back('{4'hB, 32'd9,          32'd9,          32'd0,          1});
    vecs.push_back('{4'hF, 32'd9,          32'd9,          32'd0,          1});
    vecs.push_back('{4'hC, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          33});
    vecs.push_back('{4'hC, 32'd0,          32'h1234_5678,  32'd0,          33});
    vecs.push_back('{4'hD, 32'hFFFF_FFFF,  32'd1,          DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_EN ? 33 : 1});
    vecs.push_back('{4'hE, 32'd6,          32'd7,          DIV_EN ? 32'd6 : 32'd0,  DIV_EN ? 33 : 1});

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", ALUResult, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d_op%h", i, vecs[i].op), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat);

    for (int i = 0; i < 24; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(15));
      a  = $urandom;
      b  = (i % 5 == 0) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op($sformatf("rnd%0d_op%h", i, op), op, a, b, model(op, a, b), model_lat(op, b));
    end

    // Backpressure: result must stay put and in_valid pulses must not be accepted.
    wait_idle("bp");
    out_ready = 1'b0;
    SrcA = 32'd3; SrcB = 32'd5; Operation = 4'h3; in_valid = 1'b1;
    sbq.push_back(32'hFFFF_FFFE);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_out_valid_lat1", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; Operation = 4'h2; SrcA = 32'd1; SrcB = 32'd1;
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", i), {30'd0, out_valid, in_ready}, 32'b10);
      check($sformatf("bp_result%0d", i), ALUResult, 32'hFFFF_FFFE);
    end
    in_valid = 1'b0;
    check("bp_scoreboard", ALUResult, sbq.pop_front());
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {30'd0, out_valid, in_ready}, 32'b01);
    @(posedge clk); #1;
    check("bp_no_ghost", {30'd0, out_valid, in_ready}, 32'b01);

    // Mid-operation reset during a MUL, after a non-zero result was left in ALUResult.
    wait_idle("rst");
    SrcA = 32'd3; SrcB = 32'd4; Operation = 4'hC; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("rst_busy_no_valid", {30'd0, out_valid, in_ready}, 32'b00);
    reset = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", ALUResult, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_no_partial", {31'd0, out_valid}, 32'd0);
    run_op("post_rst_add", 4'h2, 32'd1, 32'd1, 32'd2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
